// File: rtl/pixel_writer.sv
// pixel_writer
//
// Back end of the line/function generator. Each accepted (x, y, colour)
// pixel is clipped against the visible screen, turned into a linear
// framebuffer address (y * H_RES + x) and queued in a small show-ahead FIFO
// that feeds the framebuffer over a ready/valid style write port. Between
// drawing passes a clear engine can fill every framebuffer word with one
// colour. Before the fill starts, the engine lets any queued pixels finish.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   clk_enb           global clock enable; nothing advances while it is 0
//   pix_valid         pixel present on pix_x / pix_y / pix_color
//   pix_x, pix_y      unsigned pixel coordinates (SIZE bits)
//   pix_color         pixel colour (COLOR_W bits)
//   pix_ready         writer can take a pixel this cycle
//   clear_start       one-cycle request to clear the whole screen
//   clear_color       fill colour, sampled together with clear_start
//   clear_done        high whenever no clear is pending or running
//   fb_we             framebuffer write request
//   fb_addr, fb_data  write address / data, valid while fb_we is high
//   fb_ready          framebuffer accepts the write this cycle
//   drop_count        saturating count of clipped pixels
module pixel_writer #(
  parameter int SIZE       = 16,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_W    = 12,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_enb,
  input  logic               pix_valid,
  input  logic [SIZE-1:0]    pix_x,
  input  logic [SIZE-1:0]    pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               pix_ready,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_done,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ready,
  output logic [SIZE-1:0]    drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TOTAL = H_RES * V_RES;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [SIZE:0]     H_LIM     = (SIZE + 1)'(H_RES);
  localparam logic [SIZE:0]     V_LIM     = (SIZE + 1)'(V_RES);
  localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    PIX,
    DRAIN,
    CLEAR
  } state_t;

  state_t state;
  state_t state_next;

  // Stage 1 register.
  logic               s1_valid;
  logic               s1_in_range;
  logic [ADDR_W-1:0]  s1_addr;
  logic [COLOR_W-1:0] s1_color;

  // Write FIFO.
  logic [ADDR_W-1:0]  mem_addr  [FIFO_DEPTH];
  logic [COLOR_W-1:0] mem_color [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;

  // Clear engine.
  logic [ADDR_W-1:0]  clr_cnt;
  logic [COLOR_W-1:0] clr_color;

  logic               accept;
  logic               push;
  logic               pop;
  logic               xfer;
  logic               clear_take;
  logic               in_range;
  logic [ADDR_W-1:0]  addr_calc;
  logic [CNT_W:0]     occupancy;

  // Coordinates are unsigned, so a generator value of -1 (all ones) lands far
  // outside the screen and is clipped like any other overshoot. The address
  // product is formed directly at ADDR_W bits, which is exactly the
  // truncated y * H_RES + x.
  assign in_range  = ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);
  assign addr_calc = ADDR_W'(pix_y) * ADDR_W'(H_RES) + ADDR_W'(pix_x);

  // Stage 1 plus the FIFO must never hold more than FIFO_DEPTH entries.
  // Otherwise a stage-1 entry could find no room when it moves on. The
  // rst_n term keeps pix_ready low for the whole time reset is held.
  assign fifo_empty = (fifo_count == '0);
  assign occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid);
  assign pix_ready  = rst_n && (state == PIX) && (occupancy < DEPTH_LIM);
  assign clear_done = (state == PIX);

  assign accept     = pix_valid && pix_ready && clk_enb;
  assign push       = clk_enb && s1_valid && s1_in_range;
  assign xfer       = fb_we && fb_ready && clk_enb;
  assign pop        = xfer && (state != CLEAR);
  assign clear_take = clear_start && clk_enb && (state == PIX);

  // State register. The FSM only moves on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PIX;
    end else if (clk_enb) begin
      state <= state_next;
    end
  end

  // Next-state and write-port decode. The FIFO head drives the write port in
  // PIX and DRAIN. CLEAR switches the port to the fill counter. An idle port
  // shows zeros, so the reset values appear at once when reset is asserted.
  always_comb begin
    state_next = state;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = '0;
    case (state)
      PIX: begin
        if (!fifo_empty) begin
          fb_we   = 1'b1;
          fb_addr = mem_addr[rd_ptr];
          fb_data = mem_color[rd_ptr];
        end
        if (clear_start) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!fifo_empty) begin
          fb_we   = 1'b1;
          fb_addr = mem_addr[rd_ptr];
          fb_data = mem_color[rd_ptr];
        end
        if (!s1_valid && fifo_empty) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = clr_cnt;
        fb_data = clr_color;
        if (fb_ready && (clr_cnt == LAST_ADDR)) begin
          state_next = PIX;
        end
      end
      default: begin
        state_next = PIX;
      end
    endcase
  end

  // Stage 1 captures the clip decision, the linear address and the colour of
  // each accepted pixel. It is cleared whenever no pixel is accepted, so
  // every pixel passes through it for exactly one enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      s1_addr     <= '0;
      s1_color    <= '0;
    end else if (clk_enb) begin
      s1_valid <= accept;
      if (accept) begin
        s1_in_range <= in_range;
        s1_addr     <= addr_calc;
        s1_color    <= pix_color;
      end
    end
  end

  // A clipped stage-1 entry is simply not pushed. It is counted here instead,
  // and the count sticks at all ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (clk_enb && s1_valid && !s1_in_range && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  // FIFO storage has no reset. A slot is only visible on the write port
  // after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= s1_addr;
      mem_color[wr_ptr] <= s1_color;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the
  // count unchanged. The pointers wrap naturally because the depth is a
  // power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The fill colour is latched only when a clear is accepted. A request that
  // arrives while a clear is already under way cannot change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_color <= '0;
    end else if (clear_take) begin
      clr_color <= clear_color;
    end
  end

  // The fill counter sits at zero outside CLEAR, so every clear starts at
  // address 0. It steps once per accepted clear write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (clk_enb) begin
      if (state != CLEAR) begin
        clr_cnt <= '0;
      end else if (fb_ready) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer
//
// Directed bench for pixel_writer. The screen height is reduced to 8 rows so
// that a full clear (640 * 8 = 5120 words) stays short. The width stays at
// 640, so the pixel address arithmetic is the production one.
module tb_pixel_writer;

  localparam int SIZE    = 16;
  localparam int H_RES   = 640;
  localparam int V_RES   = 8;
  localparam int COLOR_W = 12;
  localparam int ADDR_W  = 19;
  localparam int DEPTH   = 4;
  localparam int TOTAL   = H_RES * V_RES;

  logic               clk;
  logic               rst_n;
  logic               clk_enb;
  logic               pix_valid;
  logic [SIZE-1:0]    pix_x;
  logic [SIZE-1:0]    pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_ready;
  logic               clear_start;
  logic [COLOR_W-1:0] clear_color;
  logic               clear_done;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_ready;
  logic [SIZE-1:0]    drop_count;

  int testsRun;
  int testsFailed;

  pixel_writer #(
    .SIZE(SIZE), .H_RES(H_RES), .V_RES(V_RES), .COLOR_W(COLOR_W),
    .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_enb(clk_enb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_ready(pix_ready),
    .clear_start(clear_start), .clear_color(clear_color), .clear_done(clear_done),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge, where inputs are driven and
  // outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input int x, input int y, input int color);
    pix_valid = valid;
    pix_x     = SIZE'(x);
    pix_y     = SIZE'(y);
    pix_color = COLOR_W'(color);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int k;
    int cyc;
    int bad;
    int n;
    logic willXfer;
    logic pulsed;

    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    clk_enb     = 1'b1;
    clear_start = 1'b0;
    clear_color = '0;
    fb_ready    = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Reset values while reset is held.
    tick();
    tick();
    checkOutput("rst_pix_ready", pix_ready, 0);
    checkOutput("rst_fb_we", fb_we, 0);
    checkOutput("rst_fb_addr", fb_addr, 0);
    checkOutput("rst_fb_data", fb_data, 0);
    checkOutput("rst_clear_done", clear_done, 1);
    checkOutput("rst_drop_count", drop_count, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_pix_ready", pix_ready, 1);

    // Three in-range pixels, each written two edges after it is accepted.
    applyStimulus(1, 0, 0, 12'hABC);
    tick();
    applyStimulus(1, 1, 0, 12'hABC);
    tick();
    checkOutput("stream0_we", fb_we, 1);
    checkOutput("stream0_addr", fb_addr, 0);
    checkOutput("stream0_data", fb_data, 12'hABC);
    applyStimulus(1, 639, 7, 12'hABC);
    tick();
    checkOutput("stream1_addr", fb_addr, 1);
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("stream2_we", fb_we, 1);
    checkOutput("stream2_addr", fb_addr, 5119);
    tick();
    checkOutput("stream_idle_we", fb_we, 0);
    checkOutput("stream_drop", drop_count, 0);

    // Clipped pixels: none may reach the framebuffer.
    applyStimulus(1, 640, 0, 12'h111);
    tick();
    applyStimulus(1, 0, 480, 12'h111);
    tick();
    checkOutput("clip_we_a", fb_we, 0);
    applyStimulus(1, 16'hFFFF, 5, 12'h111);
    tick();
    checkOutput("clip_we_b", fb_we, 0);
    applyStimulus(1, 0, 8, 12'h111);
    tick();
    checkOutput("clip_we_c", fb_we, 0);
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("clip_we_d", fb_we, 0);
    checkOutput("clip_drop4", drop_count, 4);

    // Saturation of the drop counter.
    force dut.drop_count = 16'hFFFF;
    tick();
    release dut.drop_count;
    checkOutput("sat_preload", drop_count, 16'hFFFF);
    applyStimulus(1, 700, 0, 12'h111);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    tick();
    checkOutput("sat_hold", drop_count, 16'hFFFF);
    checkOutput("sat_we", fb_we, 0);

    // Backpressure: the writer takes exactly DEPTH pixels, then stalls.
    fb_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 10 + i, 1, 12'h100 + i);
      checkOutput("bp_ready_before", pix_ready, 1);
      tick();
    end
    applyStimulus(1, 20, 1, 12'h1FF);
    checkOutput("bp_ready_full", pix_ready, 0);
    tick();
    tick();
    tick();
    checkOutput("bp_ready_hold", pix_ready, 0);
    checkOutput("bp_we_hold", fb_we, 1);
    checkOutput("bp_addr_hold", fb_addr, 650);
    checkOutput("bp_data_hold", fb_data, 12'h100);

    // With the clock enable low, nothing is popped even though fb_ready is 1.
    clk_enb  = 1'b0;
    fb_ready = 1'b1;
    tick();
    tick();
    checkOutput("freeze_addr", fb_addr, 650);
    checkOutput("freeze_we", fb_we, 1);
    clk_enb = 1'b1;
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("bp_drain_we", fb_we, 1);
      checkOutput("bp_drain_addr", fb_addr, 650 + i);
      checkOutput("bp_drain_data", fb_data, 12'h100 + i);
      tick();
    end
    checkOutput("bp_empty_we", fb_we, 0);

    // The clear request arrives alongside the third queued pixel. All three
    // pixels are written first, then the fill runs.
    fb_ready = 1'b0;
    applyStimulus(1, 20, 0, 12'h555);
    tick();
    applyStimulus(1, 21, 0, 12'h556);
    tick();
    applyStimulus(1, 22, 0, 12'h557);
    clear_start = 1'b1;
    clear_color = 12'h0F0;
    checkOutput("clr_ready_at_start", pix_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    clear_start = 1'b0;
    clear_color = 12'h000;
    checkOutput("clr_done_low", clear_done, 0);
    checkOutput("clr_pix_ready_low", pix_ready, 0);
    fb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("clr_pre_addr", fb_addr, 20 + i);
      checkOutput("clr_pre_data", fb_data, 12'h555 + i);
      tick();
    end
    checkOutput("clr_gap_we", fb_we, 0);
    checkOutput("clr_gap_done", clear_done, 0);
    tick();

    // Fill loop with a stall every fifth cycle and a second clear request
    // partway through, which must be ignored.
    k      = 0;
    cyc    = 0;
    bad    = 0;
    pulsed = 1'b0;
    while (k < TOTAL && cyc < 20000) begin
      fb_ready = ((cyc % 5) != 4);
      if (k == 1000 && !pulsed) begin
        clear_start = 1'b1;
        clear_color = 12'hF00;
        pulsed      = 1'b1;
      end else begin
        clear_start = 1'b0;
      end
      if (fb_we !== 1'b1 || fb_addr !== ADDR_W'(k) || fb_data !== 12'h0F0 ||
          clear_done !== 1'b0 || pix_ready !== 1'b0) begin
        bad++;
      end
      willXfer = fb_ready;
      tick();
      if (willXfer) k++;
      cyc++;
    end
    clear_start = 1'b0;
    fb_ready    = 1'b1;
    checkOutput("clr_all_words", k, TOTAL);
    checkOutput("clr_bad_cycles", bad, 0);
    checkOutput("clr_done_high", clear_done, 1);
    checkOutput("clr_after_we", fb_we, 0);
    tick();
    tick();
    tick();
    checkOutput("clr_once_we", fb_we, 0);
    checkOutput("clr_once_done", clear_done, 1);

    // Reset in the middle of a clear aborts it immediately.
    clear_start = 1'b1;
    clear_color = 12'h123;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (!(fb_we === 1'b1 && fb_addr === ADDR_W'(1000)) && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("rst_mid_reached_1000", (n < 3000), 1);
    checkOutput("rst_mid_data", fb_data, 12'h123);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_we", fb_we, 0);
    checkOutput("rst_mid_done", clear_done, 1);
    checkOutput("rst_mid_addr", fb_addr, 0);
    checkOutput("rst_mid_ready", pix_ready, 0);
    tick();
    checkOutput("rst_mid_we_edge", fb_we, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_mid_drop", drop_count, 0);
    checkOutput("rst_mid_ready_after", pix_ready, 1);
    applyStimulus(1, 3, 2, 12'h321);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("after_rst_we", fb_we, 1);
    checkOutput("after_rst_addr", fb_addr, 1283);
    checkOutput("after_rst_data", fb_data, 12'h321);
    tick();
    checkOutput("after_rst_idle", fb_we, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
